imem_fetch_unit: RTL and testbench

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_ram.sv | 41 ++++
 rtl/imem_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_imem_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch unit.
//   NOP_WORD_DEFAULT : ADDI x0,x0,0. It is the clear pattern and the value
//                      returned on a faulting fetch.
//   fetch_state_t    : controller states. INIT clears the array; RUN serves
//                      load and fetch traffic.
package imem_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port-write / single-port-read instruction array with a registered read.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : word index written when we=1
//   wdata : word written
//   re    : read enable; rdata updates only when re=1, otherwise it holds
//   raddr : word index read
//   rdata : registered read data, valid one cycle after re
// The array has no reset. The controller clears it explicitly after reset.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int XLEN  = 32,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the output holds its value between reads
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a program-load port and a one-cycle-latency fetch port.
// After reset the unit spends exactly DEPTH cycles writing NOP_WORD to every
// word. It then enters RUN and serves load and fetch traffic.
// Ports:
//   clk, rst                       : clock; asynchronous active-high reset
//   load_valid/load_ready          : program-load handshake
//   load_addr/load_data            : byte address and data for the load
//   load_err                       : one-cycle pulse after a bad accepted load
//   fetch_valid/fetch_ready        : fetch handshake (a pending load blocks fetch)
//   fetch_addr                     : byte PC
//   rsp_valid/rsp_instr/rsp_fault  : fetch response, one cycle after accept
//   init_done                      : high once the clear has completed
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int              DEPTH    = 64,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [31:0]     load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            load_err,
  input  logic            fetch_valid,
  output logic            fetch_ready,
  input  logic [31:0]     fetch_addr,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_instr,
  output logic            rsp_fault,
  output logic            init_done
);

  localparam int AW = $clog2(DEPTH);

  // An address is usable when it is word aligned and its word index is inside the array.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:AW+2] == {(30-AW){1'b0}});
  endfunction

  fetch_state_t    state_r;
  logic [AW-1:0]   clr_idx_r;
  logic            rsp_valid_r;
  logic            rsp_fault_r;
  logic            rsp_nop_r;     // when set, the response word is NOP_WORD instead of RAM data
  logic            load_err_r;

  logic            run_s;
  logic            load_fire_s;
  logic            load_ok_s;
  logic            fetch_fire_s;
  logic            fetch_ok_s;
  logic            ram_we_s;
  logic [AW-1:0]   ram_waddr_s;
  logic [XLEN-1:0] ram_wdata_s;
  logic            ram_re_s;
  logic [XLEN-1:0] ram_rdata_s;

  assign run_s        = (state_r == ST_RUN);
  assign load_ok_s    = addr_ok(load_addr);
  assign fetch_ok_s   = addr_ok(fetch_addr);
  assign load_fire_s  = load_valid && run_s;
  // A load wins the array. Fetches are therefore refused whenever a load is presented.
  assign fetch_ready  = run_s && !load_valid;
  assign fetch_fire_s = fetch_valid && fetch_ready;

  assign load_ready = run_s;
  assign init_done  = run_s;
  assign load_err   = load_err_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_fault  = rsp_fault_r;
  // RAM rdata only moves on an in-range read, so the response word holds between responses.
  assign rsp_instr  = rsp_nop_r ? NOP_WORD : ram_rdata_s;

  // RAM write-port steering: the clear sweep during INIT, accepted good loads during RUN
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = clr_idx_r;
    ram_wdata_s = NOP_WORD;
    if (!run_s) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_idx_r;
      ram_wdata_s = NOP_WORD;
    end else begin
      ram_we_s    = load_fire_s && load_ok_s;
      ram_waddr_s = load_addr[AW+1:2];
      ram_wdata_s = load_data;
    end
  end

  // A faulting fetch does not read the array; its response is forced to NOP_WORD.
  assign ram_re_s = fetch_fire_s && fetch_ok_s;

  // Controller FSM together with the registered response and error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      clr_idx_r   <= {AW{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
      rsp_nop_r   <= 1'b1;
      load_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          rsp_valid_r <= 1'b0;
          load_err_r  <= 1'b0;
          clr_idx_r   <= clr_idx_r + {{(AW-1){1'b0}}, 1'b1};
          if (clr_idx_r == AW'(DEPTH - 1)) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN: begin
          rsp_valid_r <= fetch_fire_s;
          load_err_r  <= load_fire_s && !load_ok_s;
          if (fetch_fire_s) begin
            rsp_fault_r <= !fetch_ok_s;
            rsp_nop_r   <= !fetch_ok_s;
          end else begin
            rsp_fault_r <= rsp_fault_r;
            rsp_nop_r   <= rsp_nop_r;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          clr_idx_r   <= {AW{1'b0}};
          rsp_valid_r <= 1'b0;
          rsp_fault_r <= 1'b0;
          rsp_nop_r   <= 1'b1;
          load_err_r  <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (fetch_addr[AW+1:2]),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit. A word-array model with a
// "cycles since reset" counter predicts every output. Directed scenarios
// with literal expectations pin the model. A long randomized run follows.
module tb_imem_fetch_unit;

  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_addr = 32'd0;
  logic [31:0] load_data = 32'd0;
  logic        load_err;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_addr = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        init_done;

  imem_fetch_unit #(.DEPTH(DEPTH), .XLEN(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_err(load_err),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_addr(fetch_addr),
    .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          cyc;              // rising edges since reset release
  logic [31:0] mem_m [DEPTH];
  logic        exp_valid, exp_fault, exp_lerr;
  logic [31:0] exp_instr;
  logic        last_fetch_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    exp_valid = 1'b0; exp_fault = 1'b0; exp_lerr = 1'b0; exp_instr = NOP;
  endtask

  // Compare registered outputs against the model (called away from the rising edge).
  task automatic check_outputs();
    chk("init_done", {31'd0, init_done}, {31'd0, (cyc >= DEPTH)});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
    chk("rsp_instr", rsp_instr, exp_instr);
    chk("load_err", {31'd0, load_err}, {31'd0, exp_lerr});
    if (exp_valid) chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
  endtask

  // One clock: drive inputs at the falling edge, check ready signals, advance the model, check results.
  task automatic cycle(input logic lv, input logic [31:0] la, input logic [31:0] ld,
                       input logic fv, input logic [31:0] fa);
    logic run;
    load_valid = lv; load_addr = la; load_data = ld;
    fetch_valid = fv; fetch_addr = fa;
    #1;
    run = (cyc >= DEPTH);
    chk("load_ready", {31'd0, load_ready}, {31'd0, run});
    chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, run && !lv});
    last_fetch_ready = fetch_ready;
    exp_lerr  = run && lv && !m_ok(la);
    exp_valid = run && fv && !lv;
    if (exp_valid) begin
      exp_fault = !m_ok(fa);
      exp_instr = m_ok(fa) ? mem_m[fa >> 2] : NOP;
    end
    if (run && lv && m_ok(la)) mem_m[la >> 2] = ld;
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // Assert reset at a falling edge for a few cycles while checking the reset-state outputs.
  task automatic apply_reset(input logic fv_during);
    @(negedge clk);
    fetch_valid = fv_during; fetch_addr = 32'h0000_000C;
    load_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst init_done", {31'd0, init_done}, 32'd0);
    chk("rst load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst fetch_ready", {31'd0, fetch_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst rsp_fault", {31'd0, rsp_fault}, 32'd0);
      chk("rst load_err", {31'd0, load_err}, 32'd0);
      chk("rst rsp_instr", rsp_instr, NOP);
    end
    fetch_valid = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    end else if (r == 7) begin
      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    end else if (r == 8) begin
      a = 32'($urandom_range(DEPTH, 2 * DEPTH)) << 2;
    end else begin
      a = $urandom;
    end
    return a;
  endfunction

  initial begin
    model_reset();
    apply_reset(1'b0);

    // Clear takes exactly DEPTH cycles.
    idle(DEPTH - 1);
    chk("init_done before 64", {31'd0, init_done}, 32'd0);
    idle(1);
    chk("init_done at 64", {31'd0, init_done}, 32'd1);

    // Fetch of a freshly cleared word.
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0000);
    chk("fetch0 valid", {31'd0, rsp_valid}, 32'd1);
    chk("fetch0 instr", rsp_instr, 32'h0000_0013);
    chk("fetch0 fault", {31'd0, rsp_fault}, 32'd0);

    // Load, then fetch on the very next cycle.
    cycle(1'b1, 32'h0000_000C, 32'h00C0_2683, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_000C);
    chk("load-fetch instr", rsp_instr, 32'h00C0_2683);
    chk("load-fetch valid", {31'd0, rsp_valid}, 32'd1);

    // Back-to-back fetches return their responses in order.
    cycle(1'b1, 32'h0000_0004, 32'hAAAA_0004, 1'b0, 32'd0);
    cycle(1'b1, 32'h0000_0008, 32'hBBBB_0008, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0000);
    chk("b2b 0", rsp_instr, 32'h0000_0013);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0004);
    chk("b2b 4", rsp_instr, 32'hAAAA_0004);
    chk("b2b 4 valid", {31'd0, rsp_valid}, 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0008);
    chk("b2b 8", rsp_instr, 32'hBBBB_0008);
    chk("b2b 8 valid", {31'd0, rsp_valid}, 32'd1);
    idle(1);
    chk("hold instr", rsp_instr, 32'hBBBB_0008);

    // Faulting fetches and a bad load.
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0002);
    chk("misalign fault", {31'd0, rsp_fault}, 32'd1);
    chk("misalign instr", rsp_instr, 32'h0000_0013);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0100);
    chk("range fault", {31'd0, rsp_fault}, 32'd1);
    chk("range instr", rsp_instr, 32'h0000_0013);
    cycle(1'b1, 32'h0000_0101, 32'hDEAD_BEEF, 1'b0, 32'd0);
    chk("load_err pulse", {31'd0, load_err}, 32'd1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0000);
    chk("load_err clears", {31'd0, load_err}, 32'd0);
    chk("bad load no write", rsp_instr, 32'h0000_0013);

    // Simultaneous load and fetch: the load wins, and the retried fetch sees the new data.
    cycle(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h0000_0010);
    chk("collide fetch_ready", {31'd0, last_fetch_ready}, 32'd0);
    chk("collide no rsp", {31'd0, rsp_valid}, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0010);
    chk("collide new data", rsp_instr, 32'h1234_5678);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) == 0, rand_addr(), $urandom,
            $urandom_range(0, 1) == 1, rand_addr());
    end

    // Reset mid-RUN with a fetch in flight, then a second reset mid-INIT.
    cycle(1'b1, 32'h0000_000C, 32'h00C0_2683, 1'b0, 32'd0);
    apply_reset(1'b1);
    chk("rerun init_done", {31'd0, init_done}, 32'd0);
    idle(20);
    apply_reset(1'b0);
    idle(DEPTH - 1);
    chk("re-clear not done", {31'd0, init_done}, 32'd0);
    idle(1);
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_000C);
    chk("re-cleared word", rsp_instr, 32'h0000_0013);
    chk("re-cleared fault", {31'd0, rsp_fault}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
